mux_rr_sched16: RTL and testbench
=================================

# mux_rr_sched16

Round-robin scheduler that shares the 16:1 bit-select mux among 16 requesters. It samples a one-hot-free request vector and picks the next requester in circular order from a rotating pointer. It drives the mux select and a one-hot grant, and holds the grant until the requester drops its request or a programmable hold limit expires. It sits directly in front of the `mux16to1` datapath and owns its `sel` input, with the mux function folded in as a gated output.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles one grant may last. Legal range 1..255.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req`  input  16  request vector; bit i = requester i wants the channel.
- `in`  input  16  mux data inputs; bit i belongs to requester i.
- `sel`  output  4  registered mux select = index of the current or last grantee.
- `grant`  output  16  registered one-hot grant; all-zero when idle.
- `valid`  output  1  registered; high while a grant is active.
- `out`  output  1  combinational, equal to `valid & in[sel]`.

## Operation
- State: 2-state FSM.
  - IDLE: no grant.
  - GRANT: channel owned by requester `sel`.
- Internal registers:
  - `ptr` [3:0]: search start.
  - `cnt`, width clog2(HOLD_CYCLES+1): grant-cycle counter.
- Reset: state=IDLE, `sel`=0, `grant`=0, `valid`=0, `ptr`=0, `cnt`=0. Hence `out`=0.
- IDLE, `req`==0: stay in IDLE; all outputs hold.
- IDLE, `req`!=0: pick the first index i with `req[i]`=1, scanning `ptr`, `ptr`+1, … mod 16.
  - Load `sel`=i, `grant`=1<<i, `valid`=1, `cnt`=1.
  - Go to GRANT.
- GRANT: release when `req[sel]`=0 or `cnt`==HOLD_CYCLES.
  - On release: `grant`=0, `valid`=0, `ptr`=(`sel`+1) mod 16, go to IDLE.
  - `sel` keeps its last value.
- GRANT, otherwise: `cnt`=`cnt`+1.
- The release condition is evaluated before any new arbitration. A grant is never handed over in the same cycle as a release; there is always one IDLE cycle between grants.
- Pointer wrap: `sel`=15 on release gives `ptr`=0. The 4-bit add drops its carry.
- Changes to requests other than `sel` during GRANT have no effect until the next IDLE cycle.
- HOLD_CYCLES=1: every grant lasts exactly one cycle, followed by one IDLE cycle.

## Timing
- Arbitration latency: `req` sampled at edge k in IDLE; `grant`/`sel`/`valid` are valid after edge k.
- Grant duration with `req[sel]` held: exactly HOLD_CYCLES cycles.
- If `req[sel]` is sampled low at edge m, `valid` falls after edge m. `valid` is still high in the cycle in which `req` was low.
- Steady state, all requesters busy: throughput is HOLD_CYCLES/(HOLD_CYCLES+1) of cycles granted.
- `out` follows `in[sel]` combinationally while `valid`=1; it is 0 otherwise.
- `rst` sampled high at any edge, including mid-grant, restores all reset values after that edge. It overrides every other transition.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=16'hFFFF and `in`=16'h3f0a -> `sel`=0, `grant`=0, `valid`=0, `out`=0 after each edge.
- Single requester, HOLD_CYCLES=4, `req`=16'h0004, `in`=16'h3f0a:
  - Expect `sel`=2, `grant`=16'h0004, `valid`=1 for 4 cycles, `out`=0.
  - Then 1 IDLE cycle, then requester 2 is regranted (scan from `ptr`=3 wraps back to 2).
- Round robin, `req`=16'h8101 held, `in`=16'h3f0a -> grant order 0, 8, 15, 0.
  - Each grant lasts 4 cycles with a 1-cycle gap.
  - `out` = 0, 1, 0, 0 respectively.
- Early release, `req`=16'h0002: drop `req` after 2 grant cycles.
  - `valid` falls on the edge that samples `req` low; total grant length 3 cycles.
  - `ptr`=2; `sel` stays 1.
- Wrap, `req`=16'hC000 from reset -> grants 14 then 15.
  - After 15 releases, `ptr`=0.
  - Setting `req`=16'h8001 in that IDLE cycle grants 0 next.
- Reset mid-grant: during a grant with `sel`=8, assert `rst` for 1 cycle -> all reset values after that edge.
  - With `req`=16'h0101 held, the next grant is 0, not 8.

Source files
------------

// File: rtl/mux_rr_sched16_if.sv
// Bundle of request/data inputs and grant/select outputs between the
// requesters and the round-robin scheduler with its folded-in 16:1 mux.
interface mux_rr_sched16_if;
  logic [15:0] req;
  logic [15:0] in;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        out;

  // Requester side: presents requests and data, observes the grant.
  modport master (
    output req, in,
    input  sel, grant, valid, out
  );

  // Scheduler side: consumes requests and data, drives the grant.
  modport slave (
    input  req, in,
    output sel, grant, valid, out
  );
endinterface

// File: rtl/mux_rr_sched16.sv
// Round-robin scheduler owning the select of a 16:1 bit mux. A grant lasts
// until its requester drops or HOLD_CYCLES expire, and every grant is
// followed by one idle cycle before the next arbitration.
module mux_rr_sched16 #(
  parameter int HOLD_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  mux_rr_sched16_if.slave bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [3:0]    ptr;
  logic [CW-1:0] cnt;
  logic [3:0]    selQ;
  logic [15:0]   grantQ;
  logic          validQ;

  logic [3:0]    pick;
  logic          found;
  logic [3:0]    idx;
  logic          release_now;

  // Find the first active request scanning circularly from ptr.
  always_comb begin
    pick  = 4'd0;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      idx = ptr + 4'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // The owner loses the channel when it drops its request or its time is up.
  always_comb begin
    release_now = !bus.req[selQ] || (cnt == HOLD_MAX);
  end

  // Grant FSM: arbitrate in IDLE, count and release in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 4'd0;
      cnt    <= '0;
      selQ   <= 4'd0;
      grantQ <= 16'd0;
      validQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            selQ   <= pick;
            grantQ <= 16'd1 << pick;
            validQ <= 1'b1;
            cnt    <= CW'(1);
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grantQ <= 16'd0;
            validQ <= 1'b0;
            ptr    <= selQ + 4'd1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered grant state drives the bus; the mux output is gated by valid.
  always_comb begin
    bus.sel   = selQ;
    bus.grant = grantQ;
    bus.valid = validQ;
    bus.out   = validQ & bus.in[selQ];
  end

endmodule

// File: tb/tb_mux_rr_sched16.sv
// Scoreboard bench for mux_rr_sched16: a cycle-level reference model pushes
// the expected outputs for every driven cycle, and a monitor compares them.
module tb_mux_rr_sched16;

  localparam int HOLD = 4;

  logic clk;
  logic rst;

  mux_rr_sched16_if intf ();

  mux_rr_sched16 #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        out;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int errors = 0;
  bit stimDone = 0;

  // Reference model state: owner of the channel (-1 when idle), the last
  // granted index, the circular search start and cycles used by the owner.
  int owner   = -1;
  int lastSel = 0;
  int mPtr    = 0;
  int held    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge given the inputs seen at that edge.
  function automatic void modelStep(input logic r, input logic [15:0] rq);
    if (r) begin
      owner   = -1;
      lastSel = 0;
      mPtr    = 0;
      held    = 0;
    end else if (owner < 0) begin
      if (rq != 16'd0) begin
        for (int k = 0; k < 16; k++) begin
          int i;
          i = (mPtr + k) % 16;
          if (rq[i]) begin
            owner   = i;
            lastSel = i;
            held    = 1;
            break;
          end
        end
      end
    end else begin
      if (!rq[owner] || held == HOLD) begin
        mPtr  = (owner + 1) % 16;
        owner = -1;
      end else begin
        held = held + 1;
      end
    end
  endfunction

  // Drive one cycle of inputs, update the model and queue the expectation.
  task automatic applyStimulus(input logic r, input logic [15:0] rq,
                               input logic [15:0] din);
    exp_t e;
    @(negedge clk);
    rst      = r;
    intf.req = rq;
    intf.in  = din;
    modelStep(r, rq);
    e.sel   = 4'(lastSel);
    e.grant = (owner >= 0) ? (16'd1 << owner) : 16'd0;
    e.valid = (owner >= 0);
    e.out   = e.valid & din[lastSel];
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [15:0] got,
                            input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Compare the DUT outputs against one queued expectation.
  task automatic checkOutput(input exp_t e);
    checkField("sel",   16'(intf.sel),   16'(e.sel));
    checkField("grant", intf.grant,      e.grant);
    checkField("valid", 16'(intf.valid), 16'(e.valid));
    checkField("out",   16'(intf.out),   16'(e.out));
  endtask

  // Monitor: just after each rising edge, pop and compare any pending result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic repeatStim(input int n, input logic r, input logic [15:0] rq,
                            input logic [15:0] din);
    for (int c = 0; c < n; c++) applyStimulus(r, rq, din);
  endtask

  initial begin
    rst      = 1'b1;
    intf.req = 16'd0;
    intf.in  = 16'd0;

    $display("[TB] reset with all requests pending");
    repeatStim(2, 1'b1, 16'hFFFF, 16'h3f0a);

    $display("[TB] single requester 2, regrant after one idle cycle");
    repeatStim(12, 1'b0, 16'h0004, 16'h3f0a);

    $display("[TB] round robin over 0, 8, 15");
    repeatStim(1, 1'b1, 16'h0000, 16'h3f0a);
    repeatStim(22, 1'b0, 16'h8101, 16'h3f0a);

    $display("[TB] early release of requester 1");
    repeatStim(1, 1'b1, 16'h0000, 16'h3f0a);
    repeatStim(3, 1'b0, 16'h0002, 16'h3f0a);
    repeatStim(3, 1'b0, 16'h0000, 16'h3f0a);

    $display("[TB] pointer wrap from 15 to 0");
    repeatStim(1, 1'b1, 16'h0000, 16'h3f0a);
    repeatStim(10, 1'b0, 16'hC000, 16'hC0F3);
    repeatStim(6, 1'b0, 16'h8001, 16'hC0F3);

    $display("[TB] reset in the middle of a grant to 8");
    repeatStim(1, 1'b1, 16'h0000, 16'h3f0a);
    repeatStim(7, 1'b0, 16'h0101, 16'h3f0a);
    repeatStim(1, 1'b1, 16'h0101, 16'h3f0a);
    repeatStim(4, 1'b0, 16'h0101, 16'h3f0a);

    $display("[TB] randomized traffic");
    repeatStim(1, 1'b1, 16'h0000, 16'h0000);
    for (int c = 0; c < 400; c++) begin
      logic [15:0] rq;
      logic        r;
      case ($urandom_range(0, 3))
        0:       rq = 16'($urandom);
        1:       rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       rq = 16'd1 << $urandom_range(0, 15);
        default: rq = 16'hFFFF;
      endcase
      r = ($urandom_range(0, 99) == 0);
      applyStimulus(r, rq, 16'($urandom));
    end
    stimDone = 1;
  end

  // Wait for the scoreboard to drain within a bounded number of cycles.
  initial begin
    int budget;
    wait (stimDone);
    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
